pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 69 ++++++
 tb/tb_pipe_hazard_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: register scoreboard that stalls decode on pending sources or a full write window,
// with a stall watchdog that latches an error state until flush.
module pipe_hazard_ctrl #(
    parameter int WDOG = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_ws,
    input  logic        id_we,
    input  logic [4:0]  wb_ws,
    input  logic        wb_we,
    input  logic        flush,
    output logic        stall,
    output logic        issue,
    output logic [31:0] pending,
    output logic [1:0]  inflight,
    output logic        err,
    output logic [15:0] stall_cnt
);
    typedef enum logic [1:0] {RUN, STALL, ERR} state_t;
    state_t state, state_n;
    logic [15:0] wd, wd_n;
    logic [31:0] pend_n, set_m, clr_m;
    logic [1:0] infl_n;
    logic wb_hit, hit1, hit2, haz, set_w;
    always_comb begin
        wb_hit = wb_we && wb_ws != 5'd0;
        // the register file is write-first, so a same-cycle writeback satisfies the source
        hit1 = pending[id_rs1] && !(wb_hit && wb_ws == id_rs1);
        hit2 = pending[id_rs2] && !(wb_hit && wb_ws == id_rs2);
        haz = id_valid && (hit1 || hit2 || inflight == 2'd3);
        stall = !flush && (state == ERR || haz);
        issue = id_valid && !stall;
        set_w = issue && id_we && id_ws != 5'd0;
        set_m = set_w ? 32'd1 << id_ws : 32'd0;
        clr_m = wb_hit ? 32'd1 << wb_ws : 32'd0;
        pend_n = (pending & ~clr_m) | set_m;
        infl_n = (set_w && !wb_hit) ? inflight + 2'd1 :
                 (wb_hit && !set_w && inflight != 2'd0) ? inflight - 2'd1 : inflight;
        wd_n = state == ERR ? wd : stall ? wd + 16'd1 : 16'd0;
        state_n = state == ERR ? ERR : !stall ? RUN : wd_n >= 16'(WDOG) ? ERR : STALL;
    end
    assign err = state == ERR;
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending   <= '0;
            inflight  <= '0;
            stall_cnt <= '0;
            wd        <= '0;
            state     <= RUN;
        end else begin
            stall_cnt <= (stall && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
            if (flush) begin
                pending  <= '0;
                inflight <= '0;
                wd       <= '0;
                state    <= RUN;
            end else begin
                pending  <= pend_n;
                inflight <= infl_n;
                wd       <= wd_n;
                state    <= state_n;
            end
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed per-cycle vectors push expected outputs into a queue;
// a negedge monitor pops and compares every cycle that has an entry.
module tb_pipe_hazard_ctrl;
    logic clk = 0, reset = 0, id_valid = 0, id_we = 0, wb_we = 0, flush = 0;
    logic [4:0] id_rs1 = 0, id_rs2 = 0, id_ws = 0, wb_ws = 0;
    logic stall, issue, err;
    logic [31:0] pending;
    logic [1:0] inflight;
    logic [15:0] stall_cnt;

    typedef struct {
        int          id;
        logic        st, is, er;
        logic [31:0] pend;
        logic [1:0]  infl;
        logic [15:0] scnt;
    } exp_t;
    exp_t q[$];
    int n_chk = 0, n_fail = 0, cyc_n = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_ws(id_ws), .id_we(id_we), .wb_ws(wb_ws), .wb_we(wb_we), .flush(flush),
        .stall(stall), .issue(issue), .pending(pending), .inflight(inflight),
        .err(err), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cycle %0d %s: got %h expected %h", id, nm, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] ws, input logic we, input logic [4:0] wws, input logic wwe,
                        input logic fl, input logic e_st, input logic e_is, input logic [31:0] e_p,
                        input logic [1:0] e_i, input logic e_err, input logic [15:0] e_s);
        @(posedge clk);
        #1;
        reset = rst; id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_ws = ws; id_we = we;
        wb_ws = wws; wb_we = wwe; flush = fl;
        cyc_n++;
        q.push_back('{cyc_n, e_st, e_is, e_err, e_p, e_i, e_s});
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("stall", e.id, 32'(stall), 32'(e.st));
                chk("issue", e.id, 32'(issue), 32'(e.is));
                chk("pending", e.id, pending, e.pend);
                chk("inflight", e.id, 32'(inflight), 32'(e.infl));
                chk("err", e.id, 32'(err), 32'(e.er));
                chk("stall_cnt", e.id, 32'(stall_cnt), 32'(e.scnt));
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        step(1,0,0,0,0,0,0,0,0, 0,0,32'h0,0,0,0);
        // r5 write then dependent read, released by same-cycle writeback
        step(1,1,0,0,5,1,0,0,0, 0,1,32'h0,0,0,0);
        step(1,1,5,0,0,0,0,0,0, 1,0,32'h20,1,0,0);
        step(1,1,5,0,0,0,0,0,0, 1,0,32'h20,1,0,1);
        step(1,1,5,0,0,0,5,1,0, 0,1,32'h20,1,0,2);
        step(1,0,0,0,0,0,0,0,0, 0,0,32'h0,0,0,2);
        // three outstanding writes fill the window
        step(1,1,0,0,1,1,0,0,0, 0,1,32'h0,0,0,2);
        step(1,1,0,0,2,1,0,0,0, 0,1,32'h2,1,0,2);
        step(1,1,0,0,3,1,0,0,0, 0,1,32'h6,2,0,2);
        step(1,1,9,10,0,0,0,0,0, 1,0,32'hE,3,0,2);
        step(1,0,0,0,0,0,1,1,0, 0,0,32'hE,3,0,3);
        step(1,0,0,0,0,0,2,1,0, 0,0,32'hC,2,0,3);
        step(1,0,0,0,0,0,3,1,0, 0,0,32'h8,1,0,3);
        step(1,0,0,0,0,0,0,0,0, 0,0,32'h0,0,0,3);
        // same-register set/clear, then different-register set/clear
        step(1,1,0,0,7,1,0,0,0, 0,1,32'h0,0,0,3);
        step(1,1,0,0,7,1,7,1,0, 0,1,32'h80,1,0,3);
        step(1,0,0,0,0,0,0,0,0, 0,0,32'h80,1,0,3);
        step(1,1,0,0,8,1,7,1,0, 0,1,32'h80,1,0,3);
        step(1,0,0,0,0,0,8,1,0, 0,0,32'h100,1,0,3);
        step(1,0,0,0,0,0,0,0,0, 0,0,32'h0,0,0,3);
        // r0 writes ignored, r0 reads never stall, decrement at zero ignored
        step(1,1,0,0,0,1,0,0,0, 0,1,32'h0,0,0,3);
        step(1,1,0,0,0,0,0,0,0, 0,1,32'h0,0,0,3);
        step(1,0,0,0,0,0,4,1,0, 0,0,32'h0,0,0,3);
        step(1,0,0,0,0,0,0,0,0, 0,0,32'h0,0,0,3);
        step(0,0,0,0,0,0,0,0,0, 0,0,32'h0,0,0,3);
        step(1,0,0,0,0,0,0,0,0, 0,0,32'h0,0,0,0);
        // watchdog trip on r4, flush in the first error cycle
        step(1,1,0,0,4,1,0,0,0, 0,1,32'h0,0,0,0);
        for (int k = 0; k < 15; k++) step(1,1,0,4,0,0,0,0,0, 1,0,32'h10,1,0,16'(k));
        step(1,1,0,4,0,0,0,0,1, 0,1,32'h10,1,1,15);
        step(1,0,0,0,0,0,0,0,0, 0,0,32'h0,0,0,15);
        // error state holds stall and keeps tracking writebacks
        step(1,1,0,0,4,1,0,0,0, 0,1,32'h0,0,0,15);
        for (int k = 0; k < 15; k++) step(1,1,0,4,0,0,0,0,0, 1,0,32'h10,1,0,16'(15 + k));
        step(1,0,0,0,0,0,4,1,0, 1,0,32'h10,1,1,30);
        step(1,0,0,0,0,0,0,0,0, 1,0,32'h0,0,1,31);
        step(1,0,0,0,0,0,0,0,1, 0,0,32'h0,0,1,32);
        step(1,0,0,0,0,0,0,0,0, 0,0,32'h0,0,0,32);
        // mid-operation reset with pending 0x24
        step(1,1,0,0,2,1,0,0,0, 0,1,32'h0,0,0,32);
        step(1,1,0,0,5,1,0,0,0, 0,1,32'h4,1,0,32);
        step(0,0,0,0,0,0,0,0,0, 0,0,32'h24,2,0,32);
        step(1,0,0,0,0,0,0,0,0, 0,0,32'h0,0,0,0);
        repeat (3) @(posedge clk);
        chk("queue_drained", cyc_n, 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
